// File: rtl/ov7670_stream_gen_if.sv
// rtl/ov7670_stream_gen_if.sv - parallel camera bus carried from the stream generator to a capture path
// Signals:
//   vsync       frame sync, active high
//   href        line valid, active high
//   d[7:0]      data byte, one per pclk
//   frame_start one-cycle pulse on the first vsync cycle of a frame
//   frame_done  one-cycle pulse on the last cycle of the vertical front porch
// Modports: master drives the bus (generator), slave observes it (capture/bench).
interface ov7670_stream_gen_if;
    logic       vsync;
    logic       href;
    logic [7:0] d;
    logic       frame_start;
    logic       frame_done;

    modport master (output vsync, output href, output d, output frame_start, output frame_done);
    modport slave  (input  vsync, input  href, input  d, input  frame_start, input  frame_done);
endinterface

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670-style VSYNC/HREF/D YUV422 stream generator with synthetic luma patterns
// Ports:
//   pclk        byte clock, one byte per cycle
//   rst_n       asynchronous active-low reset
//   en          run enable, checked in IDLE and at the end of the front porch
//   mode[1:0]   0 horizontal gradient, 1 checker, 2 vertical gradient, 3 solid
//   level[7:0]  luma used by the solid pattern
//   cam         camera bus (master side)
module ov7670_stream_gen #(
    parameter int         H_ACTIVE      = 640,
    parameter int         V_ACTIVE      = 480,
    parameter int         H_BLANK       = 288,
    parameter int         VSYNC_LINES   = 3,
    parameter int         VBP_LINES     = 17,
    parameter int         VFP_LINES     = 10,
    parameter int         Y_ON_ODD_BYTE = 1,
    parameter logic [7:0] CHROMA        = 8'h80
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [7:0]                 level,
    ov7670_stream_gen_if.master        cam
);

    localparam int LINE_CYC  = 2 * H_ACTIVE + H_BLANK;
    localparam int TOT_LINES = VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
    localparam int BC_W      = $clog2(LINE_CYC);
    localparam int LN_W      = $clog2(TOT_LINES + 1);

    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(LINE_CYC - 1);
    localparam logic [BC_W-1:0] HREF_END = BC_W'(2 * H_ACTIVE);
    localparam logic [LN_W-1:0] VFP_LAST = LN_W'(VFP_LINES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBP    = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFP    = 3'd4;

    logic [2:0]      state, state_n, seg_next;
    logic [BC_W-1:0] bc, bc_n;
    logic [LN_W-1:0] ln, ln_n, seg_last;
    logic [1:0]      mode_q;
    logic [7:0]      level_q;
    logic            line_end;
    logic            href_n;
    logic            is_y;
    logic [7:0]      x8, y8, luma, byte_n;

    // Length and successor of the current vertical segment.
    always_comb begin
        seg_last = '0;
        seg_next = S_IDLE;
        case (state)
            S_VSYNC:  begin seg_last = LN_W'(VSYNC_LINES - 1); seg_next = S_VBP;    end
            S_VBP:    begin seg_last = LN_W'(VBP_LINES - 1);   seg_next = S_ACTIVE; end
            S_ACTIVE: begin seg_last = LN_W'(V_ACTIVE - 1);    seg_next = S_VFP;    end
            S_VFP:    begin seg_last = VFP_LAST;               seg_next = en ? S_VSYNC : S_IDLE; end
            default:  ;
        endcase
    end

    assign line_end = (bc == BC_LAST);

    always_comb begin
        state_n = state;
        bc_n    = '0;
        ln_n    = '0;
        if (state == S_IDLE) begin
            if (en) state_n = S_VSYNC;
        end else if (state > S_VFP) begin
            state_n = S_IDLE;
        end else begin
            bc_n = line_end ? '0 : bc + BC_W'(1);
            ln_n = line_end ? ln + LN_W'(1) : ln;
            if (line_end && (ln == seg_last)) begin
                ln_n    = '0;
                state_n = seg_next;
            end
        end
    end

    // Outputs are derived from the next-state values so that every bus signal
    // is registered on the same edge as the state it describes.
    assign href_n = (state_n == S_ACTIVE) && (bc_n < HREF_END);
    assign x8     = 8'(bc_n >> 1);
    assign y8     = 8'(ln_n);
    assign is_y   = (Y_ON_ODD_BYTE != 0) ? bc_n[0] : ~bc_n[0];

    always_comb begin
        case (mode_q)
            2'd0:    luma = x8;
            2'd1:    luma = (x8[5] ^ y8[5]) ? 8'hFF : 8'h00;
            2'd2:    luma = y8;
            default: luma = level_q;
        endcase
    end

    assign byte_n = href_n ? (is_y ? luma : CHROMA) : 8'h00;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bc              <= '0;
            ln              <= '0;
            mode_q          <= 2'd0;
            level_q         <= 8'h00;
            cam.vsync       <= 1'b0;
            cam.href        <= 1'b0;
            cam.d           <= 8'h00;
            cam.frame_start <= 1'b0;
            cam.frame_done  <= 1'b0;
        end else begin
            state           <= state_n;
            bc              <= bc_n;
            ln              <= ln_n;
            // Pattern controls are frozen for a whole frame at VSYNC entry.
            if (state_n == S_VSYNC && state != S_VSYNC) begin
                mode_q  <= mode;
                level_q <= level;
            end
            cam.vsync       <= (state_n == S_VSYNC);
            cam.href        <= href_n;
            cam.d           <= byte_n;
            cam.frame_start <= (state_n == S_VSYNC) && (state != S_VSYNC);
            cam.frame_done  <= (state_n == S_VFP) && (bc_n == BC_LAST) && (ln_n == VFP_LAST);
        end
    end

endmodule

// File: doc/ov7670_stream_gen.md
# ov7670_stream_gen

Synthesizable OV7670 camera-side stream generator. It drives VSYNC, HREF and D[7:0] with VGA YUV422 timing, producing two bytes per pixel with a selectable synthetic luma pattern. It is the transmitter end of the parallel camera bus that the capture path receives. It substitutes for the sensor on the board (camera-less bring-up of framebuffer, overlay, ROI and CNN) and serves as the stimulus source in capture benches.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- H_BLANK, 288: blank byte-cycles per line, with HREF low.
- VSYNC_LINES, 3: lines with VSYNC high.
- VBP_LINES, 17: lines between the VSYNC falling edge and the first HREF line.
- VFP_LINES, 10: lines after the last active line, before the next VSYNC.
- Y_ON_ODD_BYTE, 1: 1 sends {chroma, Y} per pixel; 0 sends {Y, chroma}.
- CHROMA, 8'h80: value of the U/V byte.

Ports:
- pclk, in, 1: the single clock. One byte is emitted per cycle.
- rst_n, in, 1: asynchronous, active-low reset.
- en, in, 1: run enable.
- mode, in, 2: pattern select. 0 = horizontal gradient, 1 = checker, 2 = vertical gradient, 3 = solid.
- level, in, 8: luma value used in mode 3.
- vsync, out, 1: frame sync, active high.
- href, out, 1: line valid, active high.
- d, out, 8: data byte.
- frame_start, out, 1: one-cycle pulse on the first cycle that vsync is high.
- frame_done, out, 1: one-cycle pulse on the last cycle of VFP.

## Operation
- LINE_CYC = 2*H_ACTIVE + H_BLANK, which is 1568 by default.
- Frame = VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES lines, which is 510 by default.
- Frame length = 799,680 cycles by default.

States:
- IDLE: all outputs low. Enter VSYNC when en=1.
- VSYNC: vsync=1 for VSYNC_LINES*LINE_CYC cycles, then go to VBP.
- VBP: VBP_LINES*LINE_CYC cycles, then go to ACTIVE.
- ACTIVE: V_ACTIVE lines. Each line is 2*H_ACTIVE cycles with href=1, then H_BLANK cycles with href=0. After the last line's blank, go to VFP.
- VFP: VFP_LINES*LINE_CYC cycles, then go to VSYNC if en=1, else to IDLE.

Counters:
- Byte counter bc runs 0..LINE_CYC-1 and wraps.
- Line counter ln is reset at each state entry.
- Pixel x = bc[..1], valid 0..H_ACTIVE-1. y = active line index, 0..V_ACTIVE-1.
- The phase bit bc[0] selects the byte. With Y_ON_ODD_BYTE=1, phase 0 carries CHROMA and phase 1 carries Y. With 0, the order is reversed.

Luma:
- Mode 0: Y = x[7:0].
- Mode 1: Y = (x[5]^y[5]) ? 8'hFF : 8'h00.
- Mode 2: Y = y[7:0].
- Mode 3: Y = level.

Sampling and stopping:
- mode and level are sampled once on the VSYNC entry cycle and held for the whole frame. Mid-frame changes take effect on the next frame.
- en is checked only in IDLE and at the end of VFP. Deasserting en never truncates a frame.
- d = 0 whenever href = 0.

## Timing
- Reset: vsync, href, frame_start and frame_done are 0, d = 8'h00, and the state is IDLE. Reset applies immediately (asynchronously) and may occur mid-line. Outputs return to these values with no partial-line completion.
- vsync, href, d, frame_start and frame_done are all registered on the same edge, so they are mutually aligned. A receiver samples them on the following rising edge of pclk.
- Latency from en=1 in IDLE to vsync=1 is 1 cycle, and frame_start pulses on that same cycle.
- vsync falls exactly VSYNC_LINES*LINE_CYC cycles after it rises.
- The first href rise is at VBP_LINES*LINE_CYC cycles after vsync falls.
- href high runs are exactly 2*H_ACTIVE cycles. Low runs inside ACTIVE are exactly H_BLANK cycles.
- frame_done and the next frame_start are consecutive cycles when en stays 1. There is no idle gap between frames.
- x and y never exceed H_ACTIVE-1 and V_ACTIVE-1. The gradient wraps modulo 256: x=256 gives Y=0.

## Test plan
- Reset and idle: hold rst_n=0, then release with en=0 for 10k cycles. Required: vsync=href=0, d=0, no pulses.
- Frame geometry (en=1, mode 0):
  - vsync high 4704 cycles.
  - First href 26,656 cycles after vsync falls.
  - 480 href runs, each 1280 cycles, with 288-cycle gaps.
  - frame_done → frame_start period of 799,680 cycles.
- Byte content (mode 0, Y_ON_ODD_BYTE=1): at line 0, pixel 300, bytes are 8'h80 then 8'h2C. Rerun with Y_ON_ODD_BYTE=0: order is 8'h2C then 8'h80.
- Checker and solid:
  - mode 1 gives y=0,x=32 → Y=FF and y=32,x=32 → Y=00.
  - Switching to mode 3 with level=8'h5A mid-frame leaves the current frame unchanged; every Y byte of the next frame is 5A.
- Stop: drop en at line 100 of ACTIVE. The frame completes through VFP, frame_done pulses, the block enters IDLE, and no new vsync appears.
- Reset mid-line: assert rst_n=0 while href=1 at x=200. href and d go to 0 immediately. After release with en=1, the next frame starts from VSYNC with x=y=0.
